// File: rtl/uart_line_pkg.sv
// Shared types for the UART line capture block: close-reason flags, FSM states
// and the control characters it recognises.
package uart_line_pkg;
  typedef enum logic [1:0] {
    FLAG_TERM = 2'd0,
    FLAG_FULL = 2'd1,
    FLAG_BRK  = 2'd2,
    FLAG_TMO  = 2'd3
  } flag_pos_e;

  typedef logic [3:0] line_flags_t;

  typedef enum logic {ST_FILL, ST_WAIT} fill_state_e;

  localparam logic [7:0] CHAR_CR = 8'h0d;
  localparam logic [7:0] CHAR_LF = 8'h0a;

  function automatic line_flags_t flag_of(input flag_pos_e p);
    return line_flags_t'(1) << p;
  endfunction
endpackage

// File: rtl/uart_rx.sv
// UART receiver: mid-bit sampling, LSB first. A frame of all-zero data with a low
// stop bit is reported as a break, after which the line must return high.
module uart_rx #(
  parameter int BIT_RATE     = 9600,
  parameter int CLK_HZ       = 50_000_000,
  parameter int PAYLOAD_BITS = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    uart_rxd,
  input  logic                    uart_rx_en,
  output logic                    uart_rx_break,
  output logic                    uart_rx_valid,
  output logic [PAYLOAD_BITS-1:0] uart_rx_data
);
  localparam int CPB = CLK_HZ / BIT_RATE;
  localparam int CW  = $clog2(STOP_BITS * CPB + 1);
  localparam int BW  = $clog2(PAYLOAD_BITS + 1);

  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_BRKW} rx_state_e;

  rx_state_e               st;
  logic [1:0]              sync;
  logic                    rxd;
  logic [CW-1:0]           cnt;
  logic [BW-1:0]           nbit;
  logic [PAYLOAD_BITS-1:0] shreg;

  assign rxd = sync[1];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      st            <= R_IDLE;
      sync          <= 2'b11;
      cnt           <= '0;
      nbit          <= '0;
      shreg         <= '0;
      uart_rx_valid <= 1'b0;
      uart_rx_break <= 1'b0;
      uart_rx_data  <= '0;
    end else begin
      sync          <= {sync[0], uart_rxd};
      uart_rx_valid <= 1'b0;
      uart_rx_break <= 1'b0;
      case (st)
        R_IDLE: begin
          cnt  <= '0;
          nbit <= '0;
          if (uart_rx_en && !rxd) st <= R_START;
        end
        R_START: begin
          if (cnt == CW'(CPB / 2 - 1)) begin
            cnt <= '0;
            st  <= rxd ? R_IDLE : R_DATA;
          end else cnt <= cnt + 1'b1;
        end
        R_DATA: begin
          if (cnt == CW'(CPB - 1)) begin
            cnt   <= '0;
            shreg <= PAYLOAD_BITS'({rxd, shreg} >> 1);
            nbit  <= nbit + 1'b1;
            if (nbit == BW'(PAYLOAD_BITS - 1)) st <= R_STOP;
          end else cnt <= cnt + 1'b1;
        end
        R_STOP: begin
          // sample the middle of the last stop bit
          if (cnt == CW'(STOP_BITS * CPB - 1)) begin
            cnt <= '0;
            if (rxd) begin
              uart_rx_valid <= 1'b1;
              uart_rx_data  <= shreg;
              st            <= R_IDLE;
            end else begin
              uart_rx_break <= (shreg == '0);
              st            <= R_BRKW;
            end
          end else cnt <= cnt + 1'b1;
        end
        R_BRKW:  if (rxd) st <= R_IDLE;
        default: st <= R_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/uart_line_capture.sv
// Assembles received UART bytes into lines in a fill buffer and hands completed
// lines out of a hold buffer over a ready/valid port.
module uart_line_capture
  import uart_line_pkg::*;
#(
  parameter int         BIT_RATE     = 9600,
  parameter int         CLK_HZ       = 50_000_000,
  parameter int         PAYLOAD_BITS = 8,
  parameter int         STOP_BITS    = 1,
  parameter int         MAX_LEN      = 132,
  parameter logic [7:0] TERM_CHAR    = CHAR_LF,
  parameter bit         STRIP_CR     = 1'b1,
  parameter int         IDLE_CYCLES  = 0,
  parameter bit         LOG_EN       = 1'b1
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         uart_rxd,
  input  logic                         uart_rx_en,
  output logic                         line_valid,
  input  logic                         line_ready,
  output logic [MAX_LEN*8-1:0]         line_data,
  output logic [$clog2(MAX_LEN+1)-1:0] line_len,
  output logic [3:0]                   line_flags,
  output logic [15:0]                  drop_count
);
  localparam int              LW        = $clog2(MAX_LEN + 1);
  localparam int              IW        = $clog2(IDLE_CYCLES + 2);
  localparam logic [IW-1:0]   IDLE_LAST = IW'((IDLE_CYCLES > 0) ? IDLE_CYCLES - 1 : 0);
  localparam logic [LW-1:0]   LEN_MAX   = LW'(MAX_LEN);

  typedef logic [MAX_LEN-1:0][7:0] buf_t;

  logic                    rx_valid, rx_break;
  logic [PAYLOAD_BITS-1:0] rx_data;
  logic [7:0]              rx_byte;
  fill_state_e             state;
  buf_t                    fill_data, hold_data, nxt_data;
  logic [LW-1:0]           fill_len, nxt_len;
  line_flags_t             fill_flags, close_flags;
  logic [IW-1:0]           idle_cnt;
  logic                    close, hs, tmo_hit;

  uart_rx #(
    .BIT_RATE    (BIT_RATE),
    .CLK_HZ      (CLK_HZ),
    .PAYLOAD_BITS(PAYLOAD_BITS),
    .STOP_BITS   (STOP_BITS)
  ) u_rx (
    .clk          (clk),
    .resetn       (resetn),
    .uart_rxd     (uart_rxd),
    .uart_rx_en   (uart_rx_en),
    .uart_rx_break(rx_break),
    .uart_rx_valid(rx_valid),
    .uart_rx_data (rx_data)
  );

  assign rx_byte   = 8'(rx_data);
  assign hs        = line_valid & line_ready;
  assign tmo_hit   = (IDLE_CYCLES > 0) && (fill_len != '0) && !rx_valid && (idle_cnt == IDLE_LAST);
  assign line_data = hold_data;

  // if/else order gives the close priority TERM > FULL > BRK > TMO
  always_comb begin
    close_flags = '0;
    nxt_data    = fill_data;
    nxt_len     = fill_len;
    if (state == ST_FILL) begin
      if (rx_valid && !(STRIP_CR && rx_byte == CHAR_CR)) begin
        for (int i = 0; i < MAX_LEN; i++)
          if (LW'(i) == fill_len) nxt_data[i] = rx_byte;
        nxt_len = fill_len + 1'b1;
        if (rx_byte == TERM_CHAR)  close_flags = flag_of(FLAG_TERM);
        else if (nxt_len == LEN_MAX) close_flags = flag_of(FLAG_FULL);
      end else if (rx_break && fill_len != '0) begin
        close_flags = flag_of(FLAG_BRK);
      end else if (tmo_hit) begin
        close_flags = flag_of(FLAG_TMO);
      end
    end
  end

  assign close = |close_flags;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= ST_FILL;
      fill_data  <= '0;
      fill_len   <= '0;
      fill_flags <= '0;
      hold_data  <= '0;
      line_len   <= '0;
      line_flags <= '0;
      line_valid <= 1'b0;
      idle_cnt   <= '0;
      drop_count <= '0;
    end else begin
      case (state)
        ST_FILL: begin
          if (close && (!line_valid || hs)) begin
            hold_data  <= nxt_data;
            line_len   <= nxt_len;
            line_flags <= close_flags;
            line_valid <= 1'b1;
            fill_data  <= '0;
            fill_len   <= '0;
          end else begin
            fill_data <= nxt_data;
            fill_len  <= nxt_len;
            if (close) begin
              fill_flags <= close_flags;
              state      <= ST_WAIT;
            end
            if (hs) line_valid <= 1'b0;
          end
          if (close || rx_valid || fill_len == '0 || IDLE_CYCLES == 0) idle_cnt <= '0;
          else idle_cnt <= idle_cnt + 1'b1;
        end
        ST_WAIT: begin
          // fill is frozen: anything arriving now is lost, including on the release cycle
          if (rx_valid && drop_count != 16'hffff) drop_count <= drop_count + 1'b1;
          if (hs) begin
            hold_data  <= fill_data;
            line_len   <= fill_len;
            line_flags <= fill_flags;
            fill_data  <= '0;
            fill_len   <= '0;
            state      <= ST_FILL;
          end
        end
        default: state <= ST_FILL;
      endcase
    end
  end

  if (LOG_EN) begin : g_log
`ifndef SYNTHESIS
    always @(posedge clk) begin
      if (resetn && close) begin : log_line
        string s;
        s = "";
        for (int i = 0; i < MAX_LEN; i++)
          if (LW'(i) < nxt_len) s = {s, string'(nxt_data[i])};
        $display("TB_UART: %s", s);
      end
    end
`endif
  end
endmodule

// File: tb/tb_uart_line_capture.sv
// Directed bench for uart_line_capture: serial stimulus, expected lines queued as
// they are sent and compared by a monitor when the DUT hands them out.
module tb_uart_line_capture;
  localparam int MAX_LEN = 8;
  localparam int LW      = $clog2(MAX_LEN + 1);
  localparam int CPB     = 10;
  localparam int TERM = 1, FULL = 2, BRK = 4, TMO = 8;

  typedef struct packed {
    logic [MAX_LEN*8-1:0] data;
    logic [LW-1:0]        len;
    logic [3:0]           flags;
  } line_t;

  logic                 clk = 1'b0;
  logic                 resetn = 1'b0;
  logic                 uart_rxd = 1'b1;
  logic                 uart_rx_en = 1'b1;
  logic                 line_ready = 1'b1;
  logic                 line_valid;
  logic [MAX_LEN*8-1:0] line_data;
  logic [LW-1:0]        line_len;
  logic [3:0]           line_flags;
  logic [15:0]          drop_count;

  line_t exp_q[$];
  int    errors = 0;
  int    checks = 0;

  uart_line_capture #(
    .BIT_RATE    (5_000_000),
    .CLK_HZ      (50_000_000),
    .PAYLOAD_BITS(8),
    .STOP_BITS   (1),
    .MAX_LEN     (MAX_LEN),
    .TERM_CHAR   (8'h0a),
    .STRIP_CR    (1'b1),
    .IDLE_CYCLES (500),
    .LOG_EN      (1'b1)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .uart_rxd  (uart_rxd),
    .uart_rx_en(uart_rx_en),
    .line_valid(line_valid),
    .line_ready(line_ready),
    .line_data (line_data),
    .line_len  (line_len),
    .line_flags(line_flags),
    .drop_count(drop_count)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [MAX_LEN*8-1:0] mk(input string s);
    logic [MAX_LEN*8-1:0] v;
    v = '0;
    for (int i = 0; i < s.len() && i < MAX_LEN; i++) v[8*i +: 8] = s[i];
    return v;
  endfunction

  task automatic expect_line(input string s, input int flags);
    line_t e;
    e.data  = mk(s);
    e.len   = LW'(s.len());
    e.flags = 4'(flags);
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b);
    uart_rxd = b;
    tick(CPB);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(1'b1);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || line_valid) && n < budget) begin
      tick(1);
      n++;
    end
    chk("drain_pending", 64'(exp_q.size()), 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, line_valid, 0);
    chk({tag, "_data"},  line_data,  0);
    chk({tag, "_len"},   line_len,   0);
    chk({tag, "_flags"}, line_flags, 0);
    chk({tag, "_drop"},  drop_count, 0);
  endtask

  always @(negedge clk) begin : mon
    line_t e;
    if (resetn && line_valid && line_ready) begin
      if (exp_q.size() == 0) chk("unexpected_line", 64'(exp_q.size()), 1);
      else begin
        e = exp_q.pop_front();
        chk("line_data",  line_data,  e.data);
        chk("line_len",   line_len,   e.len);
        chk("line_flags", line_flags, e.flags);
      end
    end
  end

  initial begin
    #4ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    tick(5);
    chk_zero("rst");
    resetn = 1'b1;
    tick(5);

    // CR stripped, LF closes the line
    expect_line("AB\n", TERM);
    send_str("AB\r\n");
    drain(500);
    chk("s1_drop", drop_count, 0);

    // truncation at MAX_LEN, then idle timeout on the remainder
    expect_line("01234567", FULL);
    expect_line("89", TMO);
    send_str("0123456789");
    drain(2000);

    // backpressure: one held, one frozen in fill, the rest dropped
    line_ready = 1'b0;
    expect_line("X\n", TERM);
    expect_line("Y\n", TERM);
    send_str("X\nY\nZ\n");
    tick(20);
    chk("s3_drop", drop_count, 2);
    chk("s3_valid", line_valid, 1);
    chk("s3_hold_data", line_data, mk("X\n"));
    tick(50);
    chk("s3_hold_stable", line_data, mk("X\n"));
    chk("s3_len_stable", line_len, 2);
    line_ready = 1'b1;
    drain(100);
    tick(1000);
    chk("s3_drop_after", drop_count, 2);
    chk("s3_idle_valid", line_valid, 0);

    // break closes a partial line; a break on an empty fill does nothing
    expect_line("Q", BRK);
    send_byte("Q");
    uart_rxd = 1'b0;
    tick(20 * CPB);
    uart_rxd = 1'b1;
    drain(500);
    tick(50);
    uart_rxd = 1'b0;
    tick(20 * CPB);
    uart_rxd = 1'b1;
    tick(700);
    chk("s4_no_line", line_valid, 0);
    chk("s4_drop", drop_count, 2);

    // reset mid-byte with a held line and a partial fill
    line_ready = 1'b0;
    send_str("P\n");
    tick(5);
    chk("s5_held", line_valid, 1);
    send_str("AB");
    uart_rxd = 1'b0;
    tick(25);
    resetn = 1'b0;
    #1;
    uart_rxd = 1'b1;
    chk_zero("s5_rst");
    tick(5);
    chk_zero("s5_rst_hold");
    resetn = 1'b1;
    line_ready = 1'b1;
    tick(30);
    expect_line("C\n", TERM);
    send_str("C\n");
    drain(500);

    // consumer accepts the held line on the very cycle a new line closes
    line_ready = 1'b0;
    expect_line("K\n", TERM);
    expect_line("L\n", TERM);
    send_str("K\n");
    tick(5);
    send_byte("L");
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(logic'(8'h0a >> i));
    uart_rxd = 1'b1;
    for (int i = 0; i < 3 * CPB && !line_ready; i++) begin
      tick(1);
      if (dut.rx_valid) line_ready = 1'b1;
    end
    chk("s6_ready_raised", line_ready, 1);
    tick(1);
    chk("s6_valid", line_valid, 1);
    chk("s6_new_data", line_data, mk("L\n"));
    chk("s6_new_len", line_len, 2);
    chk("s6_drop", drop_count, 0);
    tick(CPB);
    drain(200);
    expect_line("M\n", TERM);
    send_str("M\n");
    drain(500);
    chk("s6_drop_end", drop_count, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_line_capture.md
Name: uart_line_capture

Overview:
- Parametrised successor to the testbench UART line logger.
- Deserialises a UART stream and assembles bytes into lines, then presents completed lines on a ready/valid output port.
- Adds a ping-pong (fill + hold) buffer, configurable line length and terminator, optional CR stripping, break/idle-timeout line closure, drop accounting and optional simulation logging.
- Used in cep_cosim benches wherever UART console text must be checked as well as logged.

Parameters:
- BIT_RATE, 9600: UART bit rate.
- CLK_HZ, 50_000_000: clk frequency.
- PAYLOAD_BITS, 8: data bits per UART frame.
- STOP_BITS, 1: stop bits per frame.
- MAX_LEN, 132: line buffer size in bytes (>=2).
- TERM_CHAR, 8'h0a: line terminator byte.
- STRIP_CR, 1: 1 = discard 8'h0d bytes.
- IDLE_CYCLES, 0: idle clocks before a partial line is flushed; 0 = timeout disabled.
- LOG_EN, 1: 1 = simulation-only `logI of each closed line.

Ports:
- clk  input  1  clock
- resetn  input  1  asynchronous active-low reset
- uart_rxd  input  1  serial receive line
- uart_rx_en  input  1  receiver enable
- line_valid  output  1  hold buffer contains a completed line
- line_ready  input  1  consumer accepts the line
- line_data  output  MAX_LEN*8  line bytes, byte 0 at [7:0]
- line_len  output  $clog2(MAX_LEN+1)  number of valid bytes
- line_flags  output  4  {TMO, BRK, FULL, TERM} close reason, one-hot
- drop_count  output  16  saturating count of dropped bytes

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (clk, resetn). While resetn=0 all state clears: line_valid=0, line_data=0, line_len=0, line_flags=0, drop_count=0, FSM=FILL, fill length=0, idle counter=0. Reset mid-line discards the partial line and any held line.
- Byte source: instantiated uart_rx delivers rx_valid, rx_data and rx_break. Capture latency is one clk from rx_valid to fill buffer update.
- FSM FILL, on rx_valid:
  - STRIP_CR=1 and byte==8'h0d: discard the byte (not stored, not dropped), restart idle counter.
  - Otherwise store the byte at index fill_len, increment fill_len, restart idle counter.
  - Byte==TERM_CHAR: store it, close with TERM.
  - Else if fill_len becomes MAX_LEN: close with FULL. There is no wrap-around; the line is truncated at MAX_LEN.
- FSM FILL, on rx_break with fill_len>0: close with BRK. A break with fill_len==0 is ignored.
- Timeout: when IDLE_CYCLES>0 and fill_len>0, the idle counter increments each clk without a stored byte. On reaching IDLE_CYCLES, close with TMO. If fill_len==0 the counter is held at 0.
- Close, hold free (or freed this same cycle by a handshake): fill copies to hold next cycle; line_valid=1; line_len and line_flags load; fill_len=0; FSM stays FILL.
- Close, hold occupied: FSM goes to WAIT. The fill buffer is frozen, and every rx_valid byte arriving in WAIT increments drop_count (saturating at 16'hffff).
- WAIT: on the handshake (line_valid & line_ready) the frozen fill moves to hold next cycle and FSM returns to FILL. A byte arriving in that same cycle is still dropped.
- Output handshake: transfer when line_valid & line_ready. line_data, line_len and line_flags are stable while line_valid=1 and ready=0. If nothing replaces the hold buffer, line_valid drops the cycle after transfer.
- Close priority within one cycle: TERM > FULL > BRK > TMO. Exactly one flag is set.
- line_data bytes at index >= line_len read 0. The fill buffer is zeroed on open.
- LOG_EN=1: on close, `logI("TB_UART: %s", …) prints the line bytes. Sim only, excluded from synthesis.

Decomposition:
- Shared package uart_line_pkg: close-reason flag typedef/enum (TERM, FULL, BRK, TMO bit positions), FSM state typedef {FILL, WAIT}, constants CHAR_CR=8'h0d and CHAR_LF=8'h0a.
- Sub-module: existing uart_rx, instantiated unchanged.
- Sub-module (optional): uart_line_buf, holding one MAX_LEN byte buffer plus length and flags, instantiated twice (fill, hold).

Test Plan:
- Bench setup for all scenarios: CLK_HZ=50M, BIT_RATE=5M (10 clk/bit), MAX_LEN=8, IDLE_CYCLES=500, line_ready=1 unless stated.
- Send "AB\r\n" -> one line: len=3, data "AB\n", flags=TERM, drop_count=0.
- Send 10 bytes "0123456789" then idle -> line 1: "01234567", len=8, FULL; line 2: "89", len=2, TMO after 500 idle clk.
- line_ready=0; send "X\n", "Y\n", "Z\n" -> hold="X\n", fill frozen="Y\n", 'Z','\n' dropped, drop_count=2. Then raise ready -> "X\n" then "Y\n" delivered, no further lines.
- Send "Q", then drive uart_rxd low for 20 bit times -> line "Q", len=1, BRK. A second break with empty fill produces no line.
- Assert resetn=0 mid-byte after "AB" is received, with a held line pending -> all outputs 0 during reset; after release, "C\n" yields len=2, data "C\n".
- Handshake consumed in the same cycle a TERM close occurs -> next cycle line_valid stays 1 with the new line, no drop, FSM remains FILL.
